// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings for the MUL/DIV sequencer: R-type decode fields, rstatus
// codes written on exception, and the sequencer FSM state encoding.
package multdiv_sequencer_pkg;

  localparam logic [4:0]  ALU_RTYPE   = 5'b00000;
  localparam logic [4:0]  ALU_MUL     = 5'b00110;
  localparam logic [4:0]  ALU_DIV     = 5'b00111;
  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] RSTATUS_MUL = 32'd4;
  localparam logic [31:0] RSTATUS_DIV = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multdiv_sequencer_md_watchdog.sv
// Busy-cycle counter for the mult/div unit; flags the last cycle the
// sequencer is willing to wait before forcing an exception.
module md_watchdog #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues start pulses to the multi-cycle mult/div unit, stalls the pipeline
// while it works, and presents a single-cycle writeback of result or rstatus.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn,
  input  logic        insn_valid,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  state_t      state, state_next;
  logic        is_div_insn, is_md, start, capture, timeout;
  logic        wd_clear, wd_expired;
  logic [4:0]  rd_q;
  logic        op_div_q;
  logic [31:0] result_q;
  logic        exc_q;
  logic        unused_insn_bits;

  assign unused_insn_bits = ^{insn[21:7], insn[1:0]};

  assign is_div_insn = (insn[6:2] == ALU_DIV);
  assign is_md   = insn_valid && (insn[31:27] == ALU_RTYPE) &&
                   ((insn[6:2] == ALU_MUL) || is_div_insn);
  assign start   = (state == ST_IDLE) && is_md && !flush;
  assign capture = (state == ST_BUSY) && !flush && md_ready;
  assign timeout = (state == ST_BUSY) && !flush && !md_ready && wd_expired;

  // Counter runs only while BUSY; any other state or a flush zeroes it.
  assign wd_clear = (state != ST_BUSY) || flush;

  md_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (state == ST_BUSY),
    .expired (wd_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      rd_q      <= '0;
      op_div_q  <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
    end else begin
      state     <= state_next;
      ctrl_mult <= start && !is_div_insn;
      ctrl_div  <= start && is_div_insn;
      if (start) begin
        rd_q     <= insn[26:22];
        op_div_q <= is_div_insn;
      end
      if (capture) begin
        result_q <= md_result;
        exc_q    <= md_exception;
      end else if (timeout) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    busy       = 1'b0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    case (state)
      ST_IDLE: begin
        // Stall is combinational from decode; masked so reset forces it low.
        if (start) begin
          stall      = reset_n;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush) begin
          state_next = ST_IDLE;
        end else if (md_ready || wd_expired) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
        if (!flush) begin
          wb_valid = 1'b1;
          wb_rd    = exc_q ? RSTATUS_REG : rd_q;
          wb_data  = exc_q ? (op_div_q ? RSTATUS_DIV : RSTATUS_MUL) : result_q;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Controls the multi-cycle multiply/divide unit behind the execute-stage ALU. Decodes MUL/DIV R-type instructions and issues a one-cycle start pulse to the mult/div unit.
- Stalls the fetch/decode/execute pipeline until the unit reports ready, or until a watchdog timeout.
- Presents a single-cycle writeback: the product or quotient to rd, or an rstatus code to $r30 on exception.

Parameters:
- MAX_CYCLES, 40, watchdog limit in BUSY cycles before forced exception.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- insn  in  32  instruction currently in execute.
- insn_valid  in  1  execute slot holds a real (non-bubble) instruction.
- flush  in  1  squash request from taken branch/jump; kills any in-flight op.
- md_result  in  32  result from the mult/div unit.
- md_exception  in  1  overflow or divide-by-zero from the unit; valid with md_ready.
- md_ready  in  1  unit result valid, single-cycle pulse.
- ctrl_mult  out  1  start-multiply pulse to the unit.
- ctrl_div  out  1  start-divide pulse to the unit.
- stall  out  1  freeze PC, F/D and D/X latches.
- busy  out  1  FSM not IDLE.
- wb_valid  out  1  writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.

Behaviour:
- Decode:
  - is_md = insn_valid & insn[31:27]==5'b00000 & (insn[6:2]==5'b00110 MUL | insn[6:2]==5'b00111 DIV).
  - rd = insn[26:22].
- FSM states: IDLE, BUSY, DONE. Reset_n low forces IDLE asynchronously and clears all registers. Every output resets to 0.
- IDLE:
  - If is_md & !flush at cycle T:
    - stall is high combinationally in cycle T.
    - Latch rd and op.
    - Clear the counter.
    - Move to BUSY.
  - ctrl_mult or ctrl_div is high for exactly one cycle, T+1 (registered; never both).
  - md_ready while in IDLE is ignored.
- BUSY:
  - stall=1 and busy=1. The counter increments each cycle, starting at 0 in T+1.
  - md_ready=1: capture md_result and md_exception, then go to DONE on the next edge. md_ready in the same cycle as the start pulse is accepted.
  - Counter == MAX_CYCLES-1 without md_ready: force exception=1 and result=0, then go to DONE.
  - md_ready and timeout in the same cycle: md_ready wins.
- DONE (one cycle):
  - stall=0, so the pipeline advances and the MUL/DIV leaves execute.
  - wb_valid=1.
  - No exception: wb_rd = latched rd, wb_data = captured result.
  - Exception: wb_rd = 30; wb_data = 4 for MUL, 5 for DIV.
  - Next state is IDLE unconditionally. is_md seen during DONE is the same retiring instruction and is not re-accepted.
- flush:
  - In any state, the next state is IDLE, no wb_valid is issued and the counter is cleared.
  - flush in the start cycle T suppresses the start pulse.
  - A late md_ready after a flush is ignored, because the FSM is in IDLE.
  - The unit is not notified. The next start re-initialises it.
- Writes to rd=0 still assert wb_valid. The regfile discards them.
- Outputs in all states other than DONE: wb_valid=0, wb_rd=0, wb_data=0.
- Latency: issue to writeback = ready cycle + 1; minimum 2 cycles after T.

Decomposition:
- Shared package: opcode constants (ALU_RTYPE 5'b00000), ALU op codes (MUL 5'b00110, DIV 5'b00111), RSTATUS_REG 5'd30, RSTATUS_MUL 32'd4, RSTATUS_DIV 32'd5, FSM state encoding.
- Sub-module: md_watchdog, a counter with clear, enable and terminal-count compare against MAX_CYCLES-1.
- Decode stays inline; the existing opcodeDecoder may supply the R-type flag.

Test Plan:
- MUL $r3=$r1*$r2 (insn aluop 00110, rd=3), unit returns md_result=32'd42 on the 17th BUSY cycle -> ctrl_mult high for 1 cycle only, stall high T..T+17, next cycle wb_valid=1, wb_rd=3, wb_data=42, then stall=0 and busy=0.
- DIV rd=7 with md_exception=1 at ready -> wb_rd=30, wb_data=5; the MUL version of the same case gives wb_data=4.
- Unit never asserts md_ready -> after exactly MAX_CYCLES (40) BUSY cycles, DONE with wb_rd=30, wb_data=5 for DIV.
- flush in the 3rd BUSY cycle, md_ready 10 cycles later -> FSM in IDLE, no wb_valid ever, stall low from the cycle after flush.
- reset_n pulled low mid-BUSY, asynchronously (not clock-aligned) -> all outputs 0 immediately, state IDLE; a later ADD insn produces no ctrl pulse and no stall.
- Back-to-back MUL, MUL with ready after 2 cycles each -> two separate ctrl_mult pulses, the second no earlier than the cycle after the first DONE, with two distinct writebacks.
